// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell is stepped LSB-first across
// WIDTH bit positions, sequenced by an IDLE/RUN/DONE FSM with valid/ready on both sides.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic             c_r;
  logic [WIDTH-1:0] sha_r;
  logic [WIDTH-1:0] shb_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [1:0]       fa_s;
  logic             last_s;
  logic             accept_s;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder built from two half adders; the two partial carries are ORed.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_add(x, y);
    h2 = half_add(h1[0], ci);
    return {h1[1] | h2[1], h2[0]};
  endfunction

  // Adder cell, last-step detect, and next-state selection.
  always_comb begin
    state_s  = state_r;
    fa_s     = full_add(sha_r[0], shb_r[0], c_r);
    last_s   = (cnt_r == CW'(WIDTH - 1));
    accept_s = (state_r == IDLE) && in_valid;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == RUN);
    end
  end

  // Operand shifters, carry flop and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      c_r    <= 1'b0;
      sha_r  <= '0;
      shb_r  <= '0;
      res_r  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sha_r <= a;
            shb_r <= op ? ~b : b;
            c_r   <= op ? 1'b1 : cin;
            cnt_r <= '0;
          end
        end
        RUN: begin
          sha_r <= {1'b0, sha_r[WIDTH-1:1]};
          shb_r <= {1'b0, shb_r[WIDTH-1:1]};
          res_r <= {fa_s[0], res_r[WIDTH-1:1]};
          c_r   <= fa_s[1];
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            // c_r here is the carry into the MSB cell.
            sum_r  <= {fa_s[0], res_r[WIDTH-1:1]};
            cout_r <= fa_s[1];
            ovf_r  <= c_r ^ fa_s[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases plus random ops
// checked against an integer-arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, op, cin, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic opx, input logic [W-1:0] ax,
                                         input logic [W-1:0] bx, input logic cx);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    logic [W-1:0] s;
    ua = int'(ax);
    ub = int'(bx);
    sa = int'($signed(ax));
    sb = int'($signed(bx));
    if (!opx) begin
      ur = ua + ub + int'(cx);
      sr = sa + sb + int'(cx);
      co = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end
    s  = ur[W-1:0];
    ov = (sr > 127) || (sr < -128);
    return {ov, co, s};
  endfunction

  // Drives one request from IDLE; returns edges until out_valid and busy-cycle count.
  task automatic run_op(input logic opx, input logic [W-1:0] ax, input logic [W-1:0] bx,
                        input logic cx, output int lat, output int bc);
    op = opx; a = ax; b = bx; cin = cx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; bc = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; cin = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags got=%b exp=100", {in_ready, out_valid, busy});
    else pass_cnt++;
    total_cnt++;
    if ({ovf, cout, sum} !== 10'd0) $display("FAIL reset_result got=%h exp=000", {ovf, cout, sum});
    else pass_cnt++;
  endtask

  task automatic test_arith();
    logic [W+1:0] exp_v;
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         to [6];
    logic         tc [6];
    int lat, bc;
    ta = '{8'h3C, 8'hFF, 8'h7F, 8'hFF, 8'h05, 8'h80};
    tb = '{8'h0F, 8'h01, 8'h01, 8'hFF, 8'h07, 8'h01};
    to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      logic ro, rc;
      logic [W-1:0] ra, rb;
      if (i < 6) begin
        ro = to[i]; ra = ta[i]; rb = tb[i]; rc = tc[i];
      end else begin
        ro = 1'($urandom); ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      end
      exp_v = model(ro, ra, rb, rc);
      run_op(ro, ra, rb, rc, lat, bc);
      total_cnt++;
      if (lat != W || bc != W) $display("FAIL arith_latency[%0d] lat=%0d busy=%0d exp=%0d", i, lat, bc, W);
      else pass_cnt++;
      total_cnt++;
      if ({ovf, cout, sum} !== exp_v)
        $display("FAIL arith_result[%0d] op=%b a=%h b=%h cin=%b got ovf/cout/sum=%b/%b/%h exp=%b/%b/%h",
                 i, ro, ra, rb, rc, ovf, cout, sum, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL arith_return[%0d] got=%b exp=100", i, {in_ready, out_valid, busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp_v;
    int lat, bc;
    out_ready = 1'b0;
    exp_v = model(1'b0, 8'h12, 8'h34, 1'b1);
    run_op(1'b0, 8'h12, 8'h34, 1'b1, lat, bc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({out_valid, in_ready, ovf, cout, sum} !== {1'b1, 1'b0, exp_v})
        $display("FAIL bp_hold[%0d] got v/r/res=%b/%b/%h exp=1/0/%h", k, out_valid, in_ready, {ovf, cout, sum}, exp_v);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid});
    else pass_cnt++;
    exp_v = model(1'b1, 8'h40, 8'hC3, 1'b0);
    run_op(1'b1, 8'h40, 8'hC3, 1'b0, lat, bc);
    total_cnt++;
    if (lat != W || {ovf, cout, sum} !== exp_v) $display("FAIL bp_second lat=%0d got=%h exp=%h", lat, {ovf, cout, sum}, exp_v);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_inval();
    logic [W+1:0] exp_v;
    int lat, nvalid;
    exp_v = model(1'b0, 8'h21, 8'h13, 1'b0);
    out_ready = 1'b0;
    op = 1'b0; a = 8'h21; b = 8'h13; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (lat == 3) begin in_valid = 1'b1; op = 1'b1; a = 8'hAA; b = 8'h55; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b1; a = 8'h99; b = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (lat != W || {out_valid, ovf, cout, sum} !== {1'b1, exp_v})
      $display("FAIL ignore_result lat=%0d got v/res=%b/%h exp=1/%h", lat, out_valid, {ovf, cout, sum}, exp_v);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1 || in_ready !== 1'b1) nvalid++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (nvalid != 0) $display("FAIL ignore_no_extra got=%0d bad cycles exp=0", nvalid);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [W+1:0] exp_v;
    int lat, bc, nv;
    out_ready = 1'b1;
    op = 1'b0; a = 8'hF0; b = 8'h0E; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy, ovf, cout, sum} !== {3'b100, 10'd0})
      $display("FAIL midrst_state got=%b/%h exp=100/000", {in_ready, out_valid, busy}, {ovf, cout, sum});
    else pass_cnt++;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid === 1'b1) nv++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (nv != 0) $display("FAIL midrst_no_valid got=%0d exp=0", nv);
    else pass_cnt++;
    exp_v = model(1'b0, 8'h5A, 8'h66, 1'b0);
    run_op(1'b0, 8'h5A, 8'h66, 1'b0, lat, bc);
    total_cnt++;
    if (lat != W || {ovf, cout, sum} !== exp_v) $display("FAIL midrst_fresh lat=%0d got=%h exp=%h", lat, {ovf, cout, sum}, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] expq [$];
    logic [W+1:0] e;
    int sent, got, last_t, t;
    logic ro, rc;
    logic [W-1:0] ra, rb;
    out_ready = 1'b1;
    sent = 0; got = 0; last_t = -1;
    for (t = 0; t < 200 && got < 6; t++) begin
      if (out_valid === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        total_cnt++;
        if ({ovf, cout, sum} !== e) $display("FAIL b2b_result[%0d] got=%h exp=%h", got, {ovf, cout, sum}, e);
        else pass_cnt++;
        if (last_t >= 0) begin
          total_cnt++;
          if (t - last_t != W + 2) $display("FAIL b2b_interval[%0d] got=%0d exp=%0d", got, t - last_t, W + 2);
          else pass_cnt++;
        end
        last_t = t;
        got++;
      end
      if (in_ready === 1'b1 && sent < 6) begin
        ro = 1'($urandom); rc = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
        op = ro; cin = rc; a = ra; b = rb; in_valid = 1'b1;
        expq.push_back(model(ro, ra, rb, rc));
        sent++;
      end else if (in_ready === 1'b1) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got != 6) $display("FAIL b2b_count got=%0d exp=6", got);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_ignore_inval();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
